// File: rtl/timer_incr_sched_pkg.sv
// Shared internal definitions for the timer increment scheduler.
//   reg_t         : register-file target selector
//   REG_*         : selector encodings used by the scheduler
//   sched_state_t : scheduler FSM states
//   TIMER_MAX     : last count value of a 14-bit timer before wrap
package internal_defines;

   typedef logic [3:0] reg_t;

   localparam reg_t REG_ZERO  = 4'h0;
   localparam reg_t REG_TIME1 = 4'hC;
   localparam reg_t REG_TIME2 = 4'hD;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      T1   = 2'd1,
      T2   = 2'd2
   } sched_state_t;

   localparam int TIMER_MAX = 16383;

   function automatic logic is_timer_reg(input reg_t sel);
      return (sel == REG_TIME1) || (sel == REG_TIME2);
   endfunction

endpackage

// File: rtl/timer_incr_sched_if.sv
// Write-port bundle between pipeline writeback, scheduler and register file.
//   pipe_wr1_en/sel             : pipeline port 1 (only watched for timer writes)
//   pipe_wr2_en/sel/data        : pipeline port 2 request
//   rf_wr2_en/sel/data          : register-file port 2 after arbitration
// master = pipeline/register-file side, slave = scheduler.
interface timer_incr_sched_if;

   logic                     pipe_wr1_en;
   internal_defines::reg_t   pipe_wr1_sel;
   logic                     pipe_wr2_en;
   internal_defines::reg_t   pipe_wr2_sel;
   logic [14:0]              pipe_wr2_data;
   logic                     rf_wr2_en;
   internal_defines::reg_t   rf_wr2_sel;
   logic [14:0]              rf_wr2_data;

   modport master (
      output pipe_wr1_en, pipe_wr1_sel, pipe_wr2_en, pipe_wr2_sel, pipe_wr2_data,
      input  rf_wr2_en, rf_wr2_sel, rf_wr2_data
   );

   modport slave (
      input  pipe_wr1_en, pipe_wr1_sel, pipe_wr2_en, pipe_wr2_sel, pipe_wr2_data,
      output rf_wr2_en, rf_wr2_sel, rf_wr2_data
   );

endinterface

// File: rtl/timer_incr_sched_pend_counter.sv
// Saturating up/down counter of pending TIME1 increments.
//   clk, rst   : clock, async active-high reset
//   inc_i      : add one (dropped when already saturated)
//   dec_i      : subtract one (only asserted when count is nonzero)
//   cnt_o      : registered count
//   cnt_d_o    : next-cycle count, used by the FSM to pick its next state
//   drop_o     : sticky flag, set when an increment was dropped at saturation
module pend_counter #(
   parameter int PEND_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc_i,
   input  logic              dec_i,
   output logic [PEND_W-1:0] cnt_o,
   output logic [PEND_W-1:0] cnt_d_o,
   output logic              drop_o
);

   localparam logic [PEND_W-1:0] CNT_MAX = '1;

   logic [PEND_W-1:0] cnt_q, cnt_d;
   logic              drop_q, drop_d;

   always_comb begin
      cnt_d  = cnt_q;
      drop_d = drop_q;
      if (inc_i && !dec_i) begin
         if (cnt_q == CNT_MAX) drop_d = 1'b1;
         else                  cnt_d  = cnt_q + 1'b1;
      end else if (dec_i && !inc_i) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         drop_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         drop_q <= drop_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign cnt_d_o = cnt_d;
   assign drop_o  = drop_q;

endmodule

// File: rtl/timer_incr_sched.sv
// Schedules hardware TIME1/TIME2 increments into register-file write port 2.
// Pipeline port-2 writes always win; the scheduler only uses a free slot.
//   clk, rst          : clock, async active-high reset
//   tick              : one-cycle request for one TIME1 increment
//   bus (slave)       : pipeline write ports in, register-file port 2 out
//   time1_q, time2_q  : register taps of TIME1/TIME2
//   t2_ovf            : one-cycle pulse, coincident with the TIME2 wrap commit
//   pend_cnt          : pending TIME1 increments
//   tick_lost         : sticky, a tick was dropped at saturation
//   stall_req         : pipeline bubble request
// Optional build macro TIMER_STARVE_STALL_EN enables stall_req; otherwise it is 0.
//
// state | meaning
// IDLE  | nothing pending
// T1    | TIME1 increments pending (pend_cnt > 0)
// T2    | TIME1 wrapped, carry into TIME2 pending (priority over T1)
module timer_incr_sched
   import internal_defines::*;
#(
   parameter int PEND_W = 4,
   parameter int T_BITS = 14
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick,
   timer_incr_sched_if.slave   bus,
   input  logic [T_BITS:0]     time1_q,
   input  logic [T_BITS:0]     time2_q,
   output logic                t2_ovf,
   output logic [PEND_W-1:0]   pend_cnt,
   output logic                tick_lost,
   output logic                stall_req
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_T1   = T1;
   localparam logic [1:0] S_T2   = T2;
   localparam logic [T_BITS-1:0] T_WRAP = T_BITS'(TIMER_MAX);

   logic [1:0]        state_q, state_d;
   logic              t2_ovf_q;
   logic              slot_free, issue_t1, issue_t2;
   logic              t1_wrap, t2_wrap;
   logic [T_BITS-1:0] t1_inc, t2_inc;
   logic [PEND_W-1:0] pend_d;
   reg_t              sched_sel;
   logic [T_BITS:0]   sched_data;
   logic              unused_tap_msb;

   assign unused_tap_msb = time1_q[T_BITS] ^ time2_q[T_BITS];

   // A software write of a timer on port 1 would race the increment, so hold off.
   assign slot_free = !bus.pipe_wr2_en && !(bus.pipe_wr1_en && is_timer_reg(bus.pipe_wr1_sel));
   assign issue_t2  = (state_q == S_T2) && slot_free;
   assign issue_t1  = (state_q == S_T1) && slot_free;

   assign t1_wrap = (time1_q[T_BITS-1:0] == T_WRAP);
   assign t2_wrap = (time2_q[T_BITS-1:0] == T_WRAP);
   assign t1_inc  = time1_q[T_BITS-1:0] + 1'b1;
   assign t2_inc  = time2_q[T_BITS-1:0] + 1'b1;

   assign sched_sel  = issue_t2 ? REG_TIME2 : REG_TIME1;
   assign sched_data = issue_t2 ? {1'b0, t2_inc} : {1'b0, t1_inc};

   pend_counter #(.PEND_W(PEND_W)) u_pend (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (tick),
      .dec_i   (issue_t1),
      .cnt_o   (pend_cnt),
      .cnt_d_o (pend_d),
      .drop_o  (tick_lost)
   );

   always_comb begin
      bus.rf_wr2_en   = 1'b0;
      bus.rf_wr2_sel  = REG_ZERO;
      bus.rf_wr2_data = '0;
      if (bus.pipe_wr2_en) begin
         bus.rf_wr2_en   = 1'b1;
         bus.rf_wr2_sel  = bus.pipe_wr2_sel;
         bus.rf_wr2_data = bus.pipe_wr2_data;
      end else if (issue_t1 || issue_t2) begin
         bus.rf_wr2_en   = 1'b1;
         bus.rf_wr2_sel  = sched_sel;
         bus.rf_wr2_data = sched_data;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (pend_d != '0) state_d = S_T1;
         S_T1: begin
            if (issue_t1) begin
               if (t1_wrap)              state_d = S_T2;
               else if (pend_d == '0)    state_d = S_IDLE;
            end
         end
         S_T2: if (issue_t2) state_d = (pend_d != '0) ? S_T1 : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         t2_ovf_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         t2_ovf_q <= issue_t2 && t2_wrap;
      end
   end

   assign t2_ovf = t2_ovf_q;

`ifdef TIMER_STARVE_STALL_EN
   localparam logic [PEND_W-1:0] PEND_NEAR_FULL = '1 - 1'b1;

   logic stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_q <= 1'b0;
      else     stall_q <= ((pend_cnt >= PEND_NEAR_FULL) || (state_q == S_T2)) && !slot_free;
   end

   assign stall_req = stall_q;
`else
   assign stall_req = 1'b0;
`endif

endmodule
